// File: rtl/lockin_frame_packer_if.sv
// Output word stream of the lock-in frame packer.
// Ports:
//   m_data_o   word payload
//   m_valid_o  payload is valid
//   m_last_o   payload is the last word of a frame
//   m_ready_i  consumer accepts the word (transfer when m_valid_o && m_ready_i)
interface lockin_frame_packer_if #(
    parameter int unsigned WORD_BITS = 32
);
    logic [WORD_BITS-1:0] m_data_o;
    logic                 m_valid_o;
    logic                 m_last_o;
    logic                 m_ready_i;

    modport master (
        output m_data_o,
        output m_valid_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/lockin_frame_packer.sv
// Snapshots lock-in results on each tick, packs them into a frame
// (counter word followed by NUM_WORDS lanes), buffers whole frames in a FIFO
// and streams them out one word per transfer. Frames that do not fit are
// dropped whole and counted.
// Ports:
//   clk_i, reset_ni   clock, synchronous active-low reset
//   tick_i            counter_i/data_i valid this cycle
//   counter_i         sample counter, frame word 0
//   data_i            lanes, lane k = data_i[k*WORD_BITS +: WORD_BITS]
//   clear_i           clears drop_count_o and overflow_o
//   m_if              output word stream (master)
//   drop_count_o      saturating count of dropped frames
//   overflow_o        sticky flag, a frame was dropped since reset/clear
module lockin_frame_packer #(
    parameter int unsigned NUM_WORDS    = 8,
    parameter int unsigned DEPTH_FRAMES = 16,
    parameter int unsigned WORD_BITS    = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic                           tick_i,
    input  logic [WORD_BITS-1:0]           counter_i,
    input  logic [NUM_WORDS*WORD_BITS-1:0] data_i,
    input  logic                           clear_i,
    lockin_frame_packer_if.master          m_if,
    output logic [15:0]                    drop_count_o,
    output logic                           overflow_o
);
    localparam int unsigned FL     = NUM_WORDS + 1;
    localparam int unsigned D      = DEPTH_FRAMES * FL;
    localparam int unsigned PTR_W  = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned OCC_W  = $clog2(D + 1) + 1;
    localparam int unsigned IDX_W  = $clog2(FL + 1);
    localparam int unsigned SNAP_W = FL * WORD_BITS;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_wr_idx;
    logic [SNAP_W-1:0]     r_snap;
    logic [WORD_BITS-1:0]  r_mem [D];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_fifo_cnt;
    logic [IDX_W-1:0]      r_rd_idx;
    logic                  r_valid;
    logic                  r_last;
    logic [WORD_BITS-1:0]  r_data;
    logic [15:0]           r_drop_cnt;
    logic                  r_ovf;

    logic [OCC_W-1:0]      w_occ;
    logic [OCC_W-1:0]      w_free;
    logic                  w_wr_en;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_rd_en;
    logic                  w_xfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy includes the word parked in the output register.
    assign w_occ   = r_fifo_cnt + OCC_W'(r_valid);
    assign w_free  = OCC_W'(D) - w_occ;
    assign w_xfer  = r_valid && m_if.m_ready_i;
    assign w_rd_en = (r_fifo_cnt != '0) && (!r_valid || m_if.m_ready_i);

    // Write FSM state register.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write FSM next state: a whole frame of space is reserved at the tick.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tick_i) begin
                    if (w_free >= OCC_W'(FL)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_wr_en = 1'b1;
                if (tick_i) begin
                    w_drop = 1'b1;
                end
                if (r_wr_idx == IDX_W'(NUM_WORDS)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Snapshot is shifted down one word per write, so word 0 is always the next to store.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_wr_idx <= '0;
            r_snap   <= '0;
        end else if (w_accept) begin
            r_wr_idx <= '0;
            r_snap   <= {data_i, counter_i};
        end else if (w_wr_en) begin
            r_wr_idx <= r_wr_idx + IDX_W'(1);
            r_snap   <= r_snap >> WORD_BITS;
        end
    end

    // Frame storage.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_snap[WORD_BITS-1:0];
        end
    end

    // Pointers, FIFO count and registered output stage.
    // r_rd_idx counts words loaded into the output register; every loaded word
    // is transferred exactly once and in order, so it tracks the transfer index.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_rd_idx   <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_en) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
                r_data   <= r_mem[r_rd_ptr];
                r_last   <= (r_rd_idx == IDX_W'(FL - 1));
                r_rd_idx <= (r_rd_idx == IDX_W'(FL - 1)) ? '0 : r_rd_idx + IDX_W'(1);
                r_valid  <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + OCC_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - OCC_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Drop accounting; a drop coinciding with clear still counts once.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (clear_i) begin
            r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
            r_ovf      <= w_drop;
        end else if (w_drop) begin
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            r_ovf <= 1'b1;
        end
    end

    assign m_if.m_data_o  = r_data;
    assign m_if.m_valid_o = r_valid;
    assign m_if.m_last_o  = r_last;
    assign drop_count_o   = r_drop_cnt;
    assign overflow_o     = r_ovf;
endmodule

// File: tb/tb_lockin_frame_packer.sv
module tb_lockin_frame_packer;
    localparam int unsigned NW = 8;
    localparam int unsigned DF = 16;
    localparam int unsigned WB = 32;
    localparam int unsigned FL = NW + 1;
    localparam int unsigned D  = DF * FL;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick;
    logic              clear;
    logic [WB-1:0]     counter;
    logic [NW*WB-1:0]  data;
    logic [15:0]       drop_count;
    logic              overflow;

    lockin_frame_packer_if #(.WORD_BITS(WB)) m_if ();

    lockin_frame_packer #(
        .NUM_WORDS    (NW),
        .DEPTH_FRAMES (DF),
        .WORD_BITS    (WB)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .tick_i       (tick),
        .counter_i    (counter),
        .data_i       (data),
        .clear_i      (clear),
        .m_if         (m_if.master),
        .drop_count_o (drop_count),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: words in flight, remaining writes of the current frame,
    // expected word stream and drop accounting, predicted one edge ahead.
    int          occ;
    int          pend;
    int          occ0;
    int          pend0;
    bit          dropped;
    int          mdrop;
    bit          movf;
    logic [WB:0] exp_q[$];
    logic [WB:0] got_q[$];
    logic [WB-1:0] mw;

    always @(negedge clk) begin
        if (!rst_n) begin
            occ = 0; pend = 0; mdrop = 0; movf = 0;
            exp_q.delete();
        end else begin
            occ0 = occ; pend0 = pend; dropped = 0;
            if (m_if.m_valid_o && m_if.m_ready_i) begin
                got_q.push_back({m_if.m_last_o, m_if.m_data_o});
                occ--;
            end
            if (pend0 > 0) begin
                occ++; pend--;
            end
            if (tick) begin
                if (pend0 == 0 && (int'(D) - occ0) >= int'(FL)) begin
                    for (int k = 0; k < int'(FL); k++) begin
                        if (k == 0) mw = counter;
                        else        mw = data[(k-1)*WB +: WB];
                        exp_q.push_back({(k == int'(FL) - 1), mw});
                    end
                    pend = FL;
                end else begin
                    dropped = 1;
                end
            end
            if (clear) begin
                mdrop = dropped ? 1 : 0;
                movf  = dropped;
            end else if (dropped) begin
                if (mdrop < 65535) mdrop++;
                movf = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; clear = 1'b0; m_if.m_ready_i = 1'b0;
        counter = '0; data = '0;
        step(); step();
        rst_n = 1'b1;
        got_q.delete();
    endtask

    task automatic do_tick(input logic [WB-1:0] c);
        counter = c;
        for (int k = 0; k < int'(NW); k++) data[k*WB +: WB] = $urandom;
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= n) begin ok = 1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({m_if.m_valid_o, m_if.m_last_o, m_if.m_data_o, drop_count, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs valid=%0b last=%0b data=%h drop=%0d ovf=%0b want all 0",
                     m_if.m_valid_o, m_if.m_last_o, m_if.m_data_o, drop_count, overflow);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        logic v1;
        do_reset();
        m_if.m_ready_i = 1'b1;
        counter = 32'd5;
        for (int k = 0; k < int'(NW); k++) data[k*WB +: WB] = WB'(k + 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        v1 = m_if.m_valid_o;
        step();
        total++;
        if (v1 !== 1'b0 || m_if.m_valid_o !== 1'b1 || m_if.m_data_o !== 32'd5) begin
            bad++;
            $display("FAIL latency valid@T+1=%0b valid@T+2=%0b data=%0d want 0,1,5",
                     v1, m_if.m_valid_o, m_if.m_data_o);
        end
        wait_got(FL, 40, ok);
        step(); step();
        total++;
        if (!ok || got_q.size() != FL) begin
            bad++;
            $display("FAIL single_count got=%0d want=%0d", got_q.size(), FL);
        end else begin
            for (int i = 0; i < int'(FL); i++) begin
                total++;
                if (got_q[i] !== {(i == int'(FL) - 1), WB'((i == 0) ? 5 : i)}) begin
                    bad++;
                    $display("FAIL single_word[%0d] got=%h want last=%0b data=%0d",
                             i, got_q[i], (i == int'(FL) - 1), (i == 0) ? 5 : i);
                end
            end
        end
        total++;
        if (drop_count !== 16'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL single_drop drop=%0d ovf=%0b want 0 0", drop_count, overflow);
        end
    endtask

    task automatic test_fill_overflow();
        bit ok;
        do_reset();
        for (int f = 0; f < 17; f++) begin
            do_tick(WB'(f + 1));
            repeat (19) step();
        end
        total++;
        if (drop_count !== 16'd1 || overflow !== 1'b1 || int'(drop_count) != mdrop) begin
            bad++;
            $display("FAIL fill_drop drop=%0d ovf=%0b want 1 1 (model %0d)", drop_count, overflow, mdrop);
        end
        m_if.m_ready_i = 1'b1;
        wait_got(D, 400, ok);
        repeat (20) step();
        total++;
        if (!ok || got_q.size() != D || exp_q.size() != D) begin
            bad++;
            $display("FAIL fill_count got=%0d model=%0d want=%0d", got_q.size(), exp_q.size(), D);
        end else begin
            for (int i = 0; i < int'(D); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL fill_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
                end
            end
            for (int f = 0; f < int'(DF); f++) begin
                total++;
                if (got_q[f*FL][WB-1:0] !== WB'(f + 1)) begin
                    bad++;
                    $display("FAIL fill_order frame %0d counter=%0d want=%0d", f, got_q[f*FL][WB-1:0], f + 1);
                end
            end
        end
    endtask

    task automatic test_ready_toggle();
        bit          hold;
        logic [WB:0] held;
        int          frames;
        int          hold_bad;
        do_reset();
        hold = 0; frames = 0; hold_bad = 0; held = '0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (hold && {m_if.m_last_o, m_if.m_data_o} !== held) begin
                hold_bad++;
                $display("FAIL toggle_hold cycle %0d data=%h want=%h", c, {m_if.m_last_o, m_if.m_data_o}, held);
            end
            if (hold) total++;
            tick = 1'b0;
            if (c % 12 == 0 && frames < 4) begin
                counter = $urandom;
                for (int k = 0; k < int'(NW); k++) data[k*WB +: WB] = $urandom;
                tick = 1'b1;
                frames++;
            end
            m_if.m_ready_i = ~m_if.m_ready_i;
            hold = m_if.m_valid_o && !m_if.m_ready_i;
            held = {m_if.m_last_o, m_if.m_data_o};
            if (frames == 4 && got_q.size() >= 4 * FL && c > 60) break;
        end
        bad += hold_bad;
        m_if.m_ready_i = 1'b1;
        tick = 1'b0;
        repeat (10) step();
        total++;
        if (got_q.size() != 4 * FL || exp_q.size() != 4 * FL) begin
            bad++;
            $display("FAIL toggle_count got=%0d model=%0d want=%0d", got_q.size(), exp_q.size(), 4 * FL);
        end else begin
            for (int i = 0; i < int'(4 * FL); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL toggle_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_tick_during_write();
        do_reset();
        m_if.m_ready_i = 1'b1;
        do_tick(32'h1111);
        step(); step();
        do_tick(32'h2222);
        repeat (30) step();
        total++;
        if (got_q.size() != FL || exp_q.size() != FL) begin
            bad++;
            $display("FAIL write_tick_count got=%0d model=%0d want=%0d", got_q.size(), exp_q.size(), FL);
        end else begin
            for (int i = 0; i < int'(FL); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL write_tick_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (drop_count !== 16'd1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL write_tick_drop drop=%0d ovf=%0b want 1 1", drop_count, overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        int stray;
        do_reset();
        do_tick(32'hA5A5_0001);
        do_tick(32'hA5A5_0002);
        repeat (15) step();
        do_tick(32'hA5A5_0003);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        total++;
        if ({m_if.m_valid_o, m_if.m_last_o, m_if.m_data_o, drop_count, overflow} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs valid=%0b last=%0b data=%h drop=%0d ovf=%0b want all 0",
                     m_if.m_valid_o, m_if.m_last_o, m_if.m_data_o, drop_count, overflow);
        end
        rst_n = 1'b1;
        m_if.m_ready_i = 1'b1;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (m_if.m_valid_o !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL midreset_idle valid high for %0d cycles want 0", stray);
        end
    endtask

    task automatic test_clear();
        do_reset();
        do_tick(32'h77);
        tick = 1'b1;
        step(); step(); step();
        tick = 1'b0;
        total++;
        if (drop_count !== 16'd3 || overflow !== 1'b1 || int'(drop_count) != mdrop) begin
            bad++;
            $display("FAIL clear_pre drop=%0d ovf=%0b want 3 1", drop_count, overflow);
        end
        step();
        tick = 1'b1; clear = 1'b1;
        step();
        tick = 1'b0; clear = 1'b0;
        total++;
        if (drop_count !== 16'd1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL clear_with_drop drop=%0d ovf=%0b want 1 1", drop_count, overflow);
        end
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++;
        if (drop_count !== 16'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL clear_alone drop=%0d ovf=%0b want 0 0", drop_count, overflow);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        do_reset();
        for (int f = 0; f < 30; f++) begin
            m_if.m_ready_i = ($urandom_range(0, 1) == 1);
            do_tick($urandom);
            for (int g = $urandom_range(0, 12); g > 0; g--) begin
                m_if.m_ready_i = ($urandom_range(0, 1) == 1);
                step();
            end
        end
        repeat (12) step();
        m_if.m_ready_i = 1'b1;
        n = exp_q.size();
        wait_got(n, 2000, ok);
        repeat (5) step();
        total++;
        if (!ok || got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL b2b_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (int'(drop_count) != mdrop || overflow !== movf) begin
            bad++;
            $display("FAIL b2b_drop drop=%0d ovf=%0b want %0d %0b", drop_count, overflow, mdrop, movf);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; clear = 1'b0; m_if.m_ready_i = 1'b0;
        counter = '0; data = '0;
        test_reset();
        test_single_frame();
        test_fill_overflow();
        test_ready_toggle();
        test_tick_during_write();
        test_reset_mid_frame();
        test_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
